// File: rtl/csa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : csa_pkg
//  Description : Elaboration helpers for the pipelined carry-select
//                adder/subtractor: parameter legality check and derivation
//                of the pipeline stage count.
//  Revision    : 1.0  initial release
// ============================================================================
package csa_pkg;

    // True when WIDTH splits into whole segments and each segment splits into
    // whole carry-select blocks. Short-circuit evaluation keeps the modulo
    // operations away from a zero divisor.
    function automatic bit csa_params_ok(input int width, input int seg, input int blk);
        return (blk >= 1) && (seg >= 1) && (width >= 1) &&
               ((seg % blk) == 0) && ((width % seg) == 0);
    endfunction

    // Number of pipeline stages; guarded so an illegal SEG still elaborates far
    // enough for the legality check to report it.
    function automatic int csa_nstg(input int width, input int seg);
        return (seg > 0) ? (width / seg) : 1;
    endfunction

endpackage : csa_pkg
`default_nettype wire

// File: rtl/csa_blk.sv
`default_nettype none
// ============================================================================
//  Module      : csa_blk
//  Description : Stateless BLK-bit carry-select block. Both candidate sums
//                (carry-in 0 and carry-in 1) are formed in parallel and the
//                incoming carry picks one sum and its carry-out.
//  Ports       : i_a, i_b  BLK-bit operands
//                i_c       block carry in (select)
//                o_s       BLK-bit sum
//                o_c       block carry out
//  Revision    : 1.0  initial release
// ============================================================================
module csa_blk #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] i_a,
    input  logic [BLK-1:0] i_b,
    input  logic           i_c,
    output logic [BLK-1:0] o_s,
    output logic           o_c
);

    logic [BLK:0] w_r0;
    logic [BLK:0] w_r1;

    assign w_r0 = {1'b0, i_a} + {1'b0, i_b};
    assign w_r1 = {1'b0, i_a} + {1'b0, i_b} + {{BLK{1'b0}}, 1'b1};

    assign {o_c, o_s} = i_c ? w_r1 : w_r0;

endmodule : csa_blk
`default_nettype wire

// File: rtl/csa_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : csa_pipe
//  Description : Pipelined carry-select adder/subtractor. One SEG-bit segment
//                is resolved per stage; unresolved operand bits and resolved
//                sum bits travel down the pipe with each beat. Global stall
//                handshake: every stage advances when the output is empty or
//                being drained.
//  Ports       : clk, rst              clock, synchronous active-high reset
//                in_valid / in_ready   operand handshake
//                a, b, c_in, sub       operands, carry in, subtract mode
//                out_valid / out_ready result handshake
//                sum, c_out, ovf       result, raw carry out, signed overflow
//  Revision    : 1.0  initial release
// ============================================================================
module csa_pipe
    import csa_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SEG   = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NSTG = csa_nstg(WIDTH, SEG);
    localparam int NBLK = (BLK > 0) ? (SEG / BLK) : 1;

    if (!csa_params_ok(WIDTH, SEG, BLK)) begin : g_param_err
        $error("csa_pipe: WIDTH must be a multiple of SEG and SEG a multiple of BLK (BLK >= 1)");
    end

    // ------------------------------------------------------------------
    // Effective operands and stall control
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_b_e;
    logic             w_cin_e;
    logic             w_en;

    assign w_b_e    = sub ? ~b : b;
    assign w_cin_e  = c_in ^ sub;
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    // ------------------------------------------------------------------
    // Stage state
    // ------------------------------------------------------------------
    logic [NSTG-1:0]            r_v;
    logic [NSTG-1:0]            r_c;
    logic [NSTG-1:0][WIDTH-1:0] r_s;
    logic                       r_ovf;

    // Per-stage segment operands, carry-out and accumulated sum.
    logic [NSTG-1:0][SEG-1:0]   w_sega;
    logic [NSTG-1:0][SEG-1:0]   w_segb;
    logic [NSTG-1:0]            w_cseg;
    logic [NSTG-1:0][WIDTH-1:0] w_snew;
    logic                       w_ovf;

    assign w_sega[0] = a[SEG-1:0];
    assign w_segb[0] = w_b_e[SEG-1:0];

    // Operand skew registers: r_a[k] holds operand bits [WIDTH-1:SEG] for the
    // beat leaving stage k. Each copy is passed whole; stage k+1 only looks
    // at its own segment. Absent entirely for a single-stage pipe.
    if (NSTG > 1) begin : g_skew
        logic [NSTG-2:0][WIDTH-SEG-1:0] r_a;
        logic [NSTG-2:0][WIDTH-SEG-1:0] r_b;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_a <= '0;
                r_b <= '0;
            end else if (w_en) begin
                r_a[0] <= a[WIDTH-1:SEG];
                r_b[0] <= w_b_e[WIDTH-1:SEG];
                for (int k = 1; k < NSTG - 1; k++) begin
                    r_a[k] <= r_a[k-1];
                    r_b[k] <= r_b[k-1];
                end
            end
        end

        for (genvar k = 1; k < NSTG; k++) begin : g_op
            assign w_sega[k] = r_a[k-1][(k-1)*SEG +: SEG];
            assign w_segb[k] = r_b[k-1][(k-1)*SEG +: SEG];
        end
    end

    // ------------------------------------------------------------------
    // Segment adders: NBLK carry-select blocks chained ripple-select
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        logic [NBLK:0]  w_bc;
        logic [SEG-1:0] w_ss;

        if (k == 0) begin : g_cin0
            assign w_bc[0]   = w_cin_e;
            assign w_snew[k] = WIDTH'(w_ss);
        end else begin : g_cink
            assign w_bc[0]   = r_c[k-1];
            assign w_snew[k] = r_s[k-1] | (WIDTH'(w_ss) << (k * SEG));
        end

        for (genvar j = 0; j < NBLK; j++) begin : g_blk
            csa_blk #(
                .BLK (BLK)
            ) u_blk (
                .i_a (w_sega[k][j*BLK +: BLK]),
                .i_b (w_segb[k][j*BLK +: BLK]),
                .i_c (w_bc[j]),
                .o_s (w_ss[j*BLK +: BLK]),
                .o_c (w_bc[j+1])
            );
        end

        assign w_cseg[k] = w_bc[NBLK];
    end

    // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ cin.
    assign w_ovf = w_cseg[NSTG-1] ^ (w_snew[NSTG-1][WIDTH-1] ^
                                     w_sega[NSTG-1][SEG-1]   ^
                                     w_segb[NSTG-1][SEG-1]);

    // ------------------------------------------------------------------
    // Stage registers: valid, carry and sum move together under w_en
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v   <= '0;
            r_c   <= '0;
            r_s   <= '0;
            r_ovf <= 1'b0;
        end else if (w_en) begin
            r_v[0] <= in_valid;
            for (int k = 1; k < NSTG; k++) begin
                r_v[k] <= r_v[k-1];
            end
            r_c   <= w_cseg;
            r_s   <= w_snew;
            r_ovf <= w_ovf;
        end
    end

    assign out_valid = r_v[NSTG-1];
    assign sum       = r_s[NSTG-1];
    assign c_out     = r_c[NSTG-1];
    assign ovf       = r_ovf;

endmodule : csa_pipe
`default_nettype wire
